// File: rtl/mips_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the responder state encoding, request payload and byte-merge helper.
package mips_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dm_state_t;

  localparam int unsigned DM_WORD_BYTES = 4;
  localparam int unsigned DM_WORD_W     = 8 * DM_WORD_BYTES;
  localparam int unsigned DM_ADDR_W     = 32;
  localparam int unsigned DM_OFS_MSB    = 1;
  localparam int unsigned DM_IDX_LSB    = 2;
  localparam int unsigned DM_IDX_W      = DM_ADDR_W - DM_IDX_LSB;

  typedef struct packed {
    logic                     we;
    logic [DM_ADDR_W-1:0]     addr;
    logic [DM_WORD_W-1:0]     wdata;
    logic [DM_WORD_BYTES-1:0] be;
  } dm_req_t;

  // Replace only the enabled byte lanes of a word.
  function automatic logic [DM_WORD_W-1:0] dm_byte_merge(
    input logic [DM_WORD_W-1:0]     old_word,
    input logic [DM_WORD_W-1:0]     new_word,
    input logic [DM_WORD_BYTES-1:0] be
  );
    logic [DM_WORD_W-1:0] r;
    r = old_word;
    for (int i = 0; i < int'(DM_WORD_BYTES); i++) begin
      if (be[i]) r[8*i +: 8] = new_word[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dm_array.sv
// Word-organised storage with byte-enabled synchronous write,
// synchronous clear of every word, and an asynchronous read port.
module dm_array
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 3072,
  parameter int unsigned AW          = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [AW-1:0]            idx,
  input  logic [DM_WORD_W-1:0]     wdata,
  input  logic [DM_WORD_BYTES-1:0] be,
  output logic [DM_WORD_W-1:0]     rword_c
);

  logic [DM_WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) mem[AW'(i)] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < int'(DM_WORD_BYTES); b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Indices past the last word read as zero rather than undefined.
  assign rword_c = (32'(idx) < DEPTH_WORDS) ? mem[idx] : '0;

endmodule

// File: rtl/dm_responder.sv
// Target side of the CPU load/store interface: accepts one request at a time,
// waits LATENCY cycles, commits the store or fetches the load, pulses ready.
module dm_responder
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 3072,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req,
  input  logic                     we,
  input  logic [DM_ADDR_W-1:0]     addr,
  input  logic [DM_WORD_W-1:0]     wdata,
  input  logic [DM_WORD_BYTES-1:0] be,
  output logic                     ready,
  output logic [DM_WORD_W-1:0]     rdata,
  output logic                     err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = 4;

  dm_state_t             state;
  logic [CW-1:0]         cnt;
  dm_req_t               lat;
  dm_req_t               cur_c;
  logic [DM_IDX_W-1:0]   index_c;
  logic                  err_c;
  logic                  go_resp_c;
  logic                  wr_en_c;
  logic [DM_WORD_W-1:0]  word_c;
  logic [DM_WORD_W-1:0]  next_word_c;

  // In IDLE the live inputs are used so a LATENCY=1 request can complete
  // on its acceptance edge; otherwise only the latched copy matters.
  always_comb begin
    cur_c = lat;
    if (state == IDLE) begin
      cur_c.we    = we;
      cur_c.addr  = addr;
      cur_c.wdata = wdata;
      cur_c.be    = be;
    end
    index_c     = cur_c.addr[DM_ADDR_W-1:DM_IDX_LSB];
    err_c       = (cur_c.addr[DM_OFS_MSB:0] != '0) ||
                  (index_c >= DM_IDX_W'(DEPTH_WORDS));
    go_resp_c   = ((state == IDLE) && req && (LATENCY == 32'd1)) ||
                  ((state == WAIT) && (cnt == CW'(1)));
    wr_en_c     = go_resp_c && cur_c.we && !err_c;
    next_word_c = cur_c.we ? dm_byte_merge(word_c, cur_c.wdata, cur_c.be) : word_c;
  end

  dm_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en_c),
    .idx     (index_c[AW-1:0]),
    .wdata   (cur_c.wdata),
    .be      (cur_c.be),
    .rword_c (word_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      lat   <= '0;
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
      case (state)
        IDLE: begin
          if (req) begin
            lat.we    <= we;
            lat.addr  <= addr;
            lat.wdata <= wdata;
            lat.be    <= be;
            cnt       <= CW'(LATENCY - 1);
            state     <= WAIT;
          end
        end
        WAIT:    cnt   <= cnt - CW'(1);
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // Completion edge: response fields are registered with the ready pulse.
      if (go_resp_c) begin
        state <= RESP;
        ready <= 1'b1;
        err   <= err_c;
        rdata <= err_c ? '0 : next_word_c;
      end
    end
  end

endmodule
